// File: rtl/sr_prog_pkg.sv
// Shared constants for the SR programming controller: register offsets,
// control/status bit positions and the shift FSM state encoding.
package sr_prog_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_LENGTH = 8'h08;
    localparam logic [7:0] OFF_DATA   = 8'h10;

    localparam int CTRL_START    = 0;
    localparam int CTRL_UPD_EN   = 1;
    localparam int CTRL_IRQ_MASK = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPD
    } state_t;

endpackage

// File: rtl/sr_prog_regs.sv
// Wishbone window decode, single-cycle ack generation and register read mux.
// Produces write strobes; the register state itself lives in the top level.
module sr_prog_regs
    import sr_prog_pkg::*;
#(
    parameter int          WIDTH     = 164,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NWORDS    = (WIDTH + 31) / 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            wb_addr,
    input  logic                   valid,
    input  logic                   wen,
    input  logic                   i_busy,
    input  logic                   i_done,
    input  logic                   i_upd_en,
    input  logic                   i_irq_mask,
    input  logic [NWORDS*32-1:0]   i_buf,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic                   o_wr_ctrl,
    output logic                   o_wr_status,
    output logic                   o_wr_data,
    output logic [5:0]             o_widx
);

    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic                    r_ready;
    logic [31:0]             r_rdata;
    logic                    w_hit;
    logic                    w_is_data;
    logic [7:0]              w_off;
    logic [5:0]              w_didx;
    logic [31:0]             w_rmux;
    logic [NWORDS-1:0][31:0] w_words;
    logic                    w_unused_addr;

    assign w_unused_addr = ^wb_addr[1:0];
    assign w_words       = i_buf;
    assign w_off         = {wb_addr[7:2], 2'b00};
    // A hit during the ack cycle is not acknowledged again.
    assign w_hit         = valid && (wb_addr[31:8] == BASE_ADDR[31:8]) && !r_ready;
    assign w_didx        = wb_addr[7:2] - OFF_DATA[7:2];
    assign w_is_data     = (w_off >= OFF_DATA) && (int'(w_didx) < NWORDS);

    always_comb begin
        w_rmux = '0;
        if (w_off == OFF_CTRL) begin
            w_rmux[CTRL_UPD_EN]   = i_upd_en;
            w_rmux[CTRL_IRQ_MASK] = i_irq_mask;
        end else if (w_off == OFF_STATUS) begin
            w_rmux[STAT_BUSY] = i_busy;
            w_rmux[STAT_DONE] = i_done;
        end else if (w_off == OFF_LENGTH) begin
            w_rmux = 32'(WIDTH);
        end else if (w_is_data) begin
            w_rmux = w_words[w_didx[IDXW-1:0]];
        end
    end

    assign o_wr_ctrl   = w_hit && wen && (w_off == OFF_CTRL);
    assign o_wr_status = w_hit && wen && (w_off == OFF_STATUS);
    assign o_wr_data   = w_hit && wen && w_is_data;
    assign o_widx      = w_didx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_hit;
            r_rdata <= (w_hit && !wen) ? w_rmux : '0;
        end
    end

    assign ready = r_ready;
    assign rdata = r_rdata;

endmodule

// File: rtl/sr_prog_ctrl.sv
// Shadow-buffer programmer for the configuration shift register: shifts the
// buffer into the chain LSB first while capturing the old chain contents.
// Optional done interrupt and CTRL.IRQ_MASK with `define SR_PROG_IRQ_EN.
module sr_prog_ctrl
    import sr_prog_pkg::*;
#(
    parameter int          WIDTH     = 164,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NWORDS    = (WIDTH + 31) / 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] wb_addr,
    input  logic        valid,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sr_sin,
    input  logic        sr_sout,
    output logic        sr_shift,
    output logic        sr_update
`ifdef SR_PROG_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CNTW = $clog2(WIDTH + 1);

    state_t               r_state;
    logic [CNTW-1:0]      r_cnt;
    logic [WIDTH-1:0]     r_buf;
    logic                 r_sin;
    logic                 r_shift;
    logic                 r_update;
    logic                 r_done;
    logic                 r_upd_en;
    logic                 r_irq_mask;
    logic [WIDTH-1:0]     w_buf_shift;
    logic [NWORDS*32-1:0] w_buf_pad;
    logic                 w_busy;
    logic                 w_start;
    logic                 w_wr_ctrl;
    logic                 w_wr_status;
    logic                 w_wr_data;
    logic [5:0]           w_widx;

    assign w_busy  = (r_state != IDLE);
    assign w_start = w_wr_ctrl && wstrb[0] && wdata[CTRL_START] && !w_busy;

    always_comb begin
        w_buf_pad              = '0;
        w_buf_pad[WIDTH-1:0]   = r_buf;
    end

    generate
        if (WIDTH > 1) begin : g_shift
            assign w_buf_shift = {sr_sout, r_buf[WIDTH-1:1]};
        end else begin : g_shift1
            assign w_buf_shift = sr_sout;
        end
    endgenerate

    sr_prog_regs #(
        .WIDTH     (WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .NWORDS    (NWORDS)
    ) u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .wb_addr     (wb_addr),
        .valid       (valid),
        .wen         (wen),
        .i_busy      (w_busy),
        .i_done      (r_done),
        .i_upd_en    (r_upd_en),
        .i_irq_mask  (r_irq_mask),
        .i_buf       (w_buf_pad),
        .rdata       (rdata),
        .ready       (ready),
        .o_wr_ctrl   (w_wr_ctrl),
        .o_wr_status (w_wr_status),
        .o_wr_data   (w_wr_data),
        .o_widx      (w_widx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_upd_en   <= 1'b0;
            r_irq_mask <= 1'b0;
        end else if (w_wr_ctrl && wstrb[0] && !w_busy) begin
            r_upd_en   <= wdata[CTRL_UPD_EN];
`ifdef SR_PROG_IRQ_EN
            r_irq_mask <= wdata[CTRL_IRQ_MASK];
`endif
        end
    end

    // Bits past WIDTH in the last word have no storage and read back as 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_buf <= '0;
        end else if (r_state == SHIFT) begin
            r_buf <= w_buf_shift;
        end else if (w_wr_data && !w_busy) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (w_widx == 6'(b / 32) && wstrb[(b % 32) / 8])
                    r_buf[b] <= wdata[b % 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sin    <= 1'b0;
            r_shift  <= 1'b0;
            r_update <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (w_wr_status && wdata[STAT_DONE])
                r_done <= 1'b0;
            // Completion below overrides a same-cycle write-1-clear.
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= SHIFT;
                        r_cnt   <= CNTW'(WIDTH);
                        r_done  <= 1'b0;
                        r_shift <= 1'b1;
                        r_sin   <= r_buf[0];
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_sin <= w_buf_shift[0];
                    if (r_cnt == CNTW'(1)) begin
                        r_shift <= 1'b0;
                        r_sin   <= 1'b0;
                        if (r_upd_en) begin
                            r_state  <= UPD;
                            r_update <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                UPD: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sr_sin    = r_sin;
    assign sr_shift  = r_shift;
    assign sr_update = r_update;

`ifdef SR_PROG_IRQ_EN
    assign irq = r_done & r_irq_mask;
`endif

endmodule

// File: tb/tb_sr_prog_ctrl.sv
// Scoreboard bench for sr_prog_ctrl: bus expectations are queued at issue and
// checked by a monitor on each ack; a chain model sits on the serial pins.
module tb_sr_prog_ctrl;

    localparam int          W    = 164;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] wb_addr;
    logic        valid;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sr_sin;
    logic        sr_sout;
    logic        sr_shift;
    logic        sr_update;
`ifdef SR_PROG_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    sr_prog_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb_addr   (wb_addr),
        .valid     (valid),
        .wen       (wen),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .sr_sin    (sr_sin),
        .sr_sout   (sr_sout),
        .sr_shift  (sr_shift),
        .sr_update (sr_update)
`ifdef SR_PROG_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    // Chain model: enters at the top, leaves from bit 0.
    logic [W-1:0] chain;
    logic [W-1:0] load_val;
    logic         load_req;
    assign sr_sout = chain[0];
    always @(posedge clk) begin
        if (load_req)      chain <= load_val;
        else if (sr_shift) chain <= {sr_sin, chain[W-1:1]};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    bit          q_rd[$];
    logic [31:0] q_exp[$];
    string       q_nm[$];
    int          ack_total = 0;

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            ack_total++;
            if (q_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_ack: ready=1 with no transaction outstanding");
            end else begin
                bit          r;
                logic [31:0] e;
                string       nm;
                r  = q_rd.pop_front();
                e  = q_exp.pop_front();
                nm = q_nm.pop_front();
                if (r) check(nm, rdata, e);
            end
        end
    end

    int cyc = 0, sh_total = 0, up_total = 0, last_sh = 0, up_cyc = 0;
    bit sin_hist [0:4095];
    always @(negedge clk) begin
        cyc++;
        if (sr_shift === 1'b1) begin
            if (sh_total < 4096) sin_hist[sh_total] = sr_sin;
            sh_total++;
            last_sh = cyc;
        end
        if (sr_update === 1'b1) begin
            up_total++;
            up_cyc = cyc;
        end
    end

    task automatic wb(input logic [31:0] a, input bit we, input logic [3:0] st,
                      input logic [31:0] d, input bit ack, input logic [31:0] exp,
                      input string nm, input int hold = 1);
        @(negedge clk);
        if (ack) begin
            q_rd.push_back(!we);
            q_exp.push_back(exp);
            q_nm.push_back(nm);
        end
        wb_addr = a; valid = 1'b1; wen = we; wstrb = st; wdata = d;
        repeat (hold) @(negedge clk);
        valid = 1'b0; wen = 1'b0; wstrb = 4'h0; wdata = '0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        wb(BASE + 32'(off), 1'b1, 4'hF, d, 1'b1, 32'h0, "wr");
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
        wb(BASE + 32'(off), 1'b0, 4'hF, 32'h0, 1'b1, exp, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sh0, up0, base_ack;
        logic [7:0]  f8;
        bit          found;

        reset_n = 1'b0; valid = 1'b0; wen = 1'b0; wstrb = 4'h0; wdata = '0; wb_addr = '0;
        load_val = '0; load_req = 1'b1;
        repeat (3) @(negedge clk);
        load_req = 1'b0;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_sin", 32'(sr_sin), 32'h0);
        check("rst_shift", 32'(sr_shift), 32'h0);
        check("rst_update", 32'(sr_update), 32'h0);
`ifdef SR_PROG_IRQ_EN
        check("rst_irq", 32'(irq), 32'h0);
`endif
        reset_n = 1'b1;

        rd(8'h04, 32'h0, "status_rst");
        rd(8'h08, 32'd164, "length");
        rd(8'h00, 32'h0, "ctrl_rst");
        wr(8'h0C, 32'hDEADBEEF);
        rd(8'h0C, 32'h0, "unmapped_rd");
        wb(BASE + 32'h08, 1'b0, 4'hF, 32'h0, 1'b1, 32'd164, "length_held_valid", 2);

        base_ack = ack_total;
        wb(BASE + 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, "outside_hi");
        wb(32'h2FFF_FF00, 1'b1, 4'hF, 32'h1, 1'b0, 32'h0, "outside_lo");
        repeat (2) @(negedge clk);
        check("no_ack_outside", 32'(ack_total - base_ack), 32'h0);

        wr(8'h24, 32'hFFFF_FFFF);
        rd(8'h24, 32'h0000_000F, "data5_width_mask");
        wb(BASE + 32'h14, 1'b1, 4'b0101, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr_strb");
        rd(8'h14, 32'h00FF_00FF, "data1_strobes");
        wr(8'h10, 32'hA5A5_A5A5);
        for (int k = 1; k < 6; k++) wr(8'(8'h10 + 4 * k), 32'h0);
        rd(8'h10, 32'hA5A5_A5A5, "data0_wr");

        // Run 1: program A5 pattern with update, chain preloaded for readback.
        @(negedge clk);
        load_val = '0; load_val[31:0] = 32'h1234_5678; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        sh0 = sh_total; up0 = up_total;
        wr(8'h00, 32'h3);
        repeat (200) @(negedge clk);
        check("run1_shift_len", 32'(sh_total - sh0), 32'd164);
        for (int i = 0; i < 8; i++) f8[i] = sin_hist[sh0 + i];
        check("run1_sin_first8", 32'(f8), 32'hA5);
        check("run1_update_count", 32'(up_total - up0), 32'd1);
        check("run1_update_after_last", 32'(up_cyc - last_sh), 32'd1);
        check("run1_chain_lo", chain[31:0], 32'hA5A5_A5A5);
        check("run1_chain_hi", 32'(|chain[W-1:32]), 32'h0);
        rd(8'h04, 32'h2, "run1_status");
        rd(8'h00, 32'h2, "ctrl_start_selfclear");
        rd(8'h10, 32'h1234_5678, "readback_d0");
        rd(8'h14, 32'h0, "readback_d1");

        // Run 2: no update; data/ctrl writes and restart while busy.
        sh0 = sh_total; up0 = up_total;
        wr(8'h00, 32'h1);
        repeat (20) @(negedge clk);
        wr(8'h18, 32'hFFFF_FFFF);
        wr(8'h00, 32'h3);
        rd(8'h04, 32'h1, "busy_status");
        repeat (200) @(negedge clk);
        check("run2_shift_len", 32'(sh_total - sh0), 32'd164);
        check("run2_no_update", 32'(up_total - up0), 32'd0);
        check("run2_chain_lo", chain[31:0], 32'h1234_5678);
        check("run2_chain_hi", 32'(|chain[W-1:32]), 32'h0);
        rd(8'h18, 32'h0, "busy_d2_unaffected");
        rd(8'h10, 32'hA5A5_A5A5, "readback2_d0");
        rd(8'h00, 32'h0, "busy_ctrl_ignored");
        rd(8'h04, 32'h2, "run2_status");
        wr(8'h04, 32'h2);
        rd(8'h04, 32'h0, "done_w1c");

        // Run 3: reset mid-shift.
        sh0 = sh_total;
        found = 1'b0;
        wr(8'h00, 32'h1);
        for (int i = 0; i < 200; i++) begin
            if (sh_total - sh0 >= 50) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_mid_reached_50", 32'(found), 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_shift_low", 32'(sr_shift), 32'h0);
        reset_n = 1'b1;
        sh0 = sh_total;
        repeat (5) @(negedge clk);
        check("rst_mid_no_more_shift", 32'(sh_total - sh0), 32'h0);
        rd(8'h04, 32'h0, "rst_mid_status");

`ifdef SR_PROG_IRQ_EN
        wr(8'h00, 32'h5);
        repeat (200) @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        rd(8'h00, 32'h4, "irq_mask_rd");
        wr(8'h04, 32'h2);
        check("irq_clear", 32'(irq), 32'h0);
`endif

        repeat (3) @(negedge clk);
        check("ack_queue_drained", 32'(q_rd.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
